// File: rtl/exec_md_pkg.sv
// Shared definitions for the EX-stage ALU and the iterative multiply/divide
// engine: operation codes, FSM state encoding and the default datapath width.
package exec_md_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_MUL  = 4'd6,
        OP_DIVU = 4'd7,
        OP_REMU = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Which result the iterative engine hands back when it finishes
    typedef enum logic [1:0] {
        MD_MUL  = 2'd0,
        MD_DIVU = 2'd1,
        MD_REMU = 2'd2
    } md_kind_e;

    function automatic logic is_md_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_illegal_op(input logic [3:0] op);
        return op > OP_REMU;
    endfunction

    function automatic md_kind_e md_kind_of(input logic [3:0] op);
        md_kind_e k;
        if (op == OP_MUL)
            k = MD_MUL;
        else if (op == OP_DIVU)
            k = MD_DIVU;
        else
            k = MD_REMU;
        return k;
    endfunction

endpackage

// File: rtl/exec_muldiv_stage_if.sv
// ID/EX -> EX/MEM bundle of the execute stage. The master side is the
// pipeline around the stage (ID/EX register, hazard unit, MEM stage); the
// slave side is the execute stage itself.
interface exec_muldiv_stage_if #(
    parameter int WIDTH = exec_md_pkg::DEF_WIDTH,
    parameter int RADDR = 3
);
    logic             in_valid;
    logic [3:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [RADDR-1:0] wr_reg;
    logic             reg_write;
    logic             flush;
    logic             mem_stall;
    logic             stall_out;
    logic [WIDTH-1:0] res_exmem;
    logic [RADDR-1:0] wr_reg_exmem;
    logic             reg_write_exmem;
    logic             valid_exmem;
    logic             div0_exmem;
    logic             err_exmem;

    modport master (
        output in_valid, op, op_a, op_b, wr_reg, reg_write, flush, mem_stall,
        input  stall_out, res_exmem, wr_reg_exmem, reg_write_exmem,
               valid_exmem, div0_exmem, err_exmem
    );

    modport slave (
        input  in_valid, op, op_a, op_b, wr_reg, reg_write, flush, mem_stall,
        output stall_out, res_exmem, wr_reg_exmem, reg_write_exmem,
               valid_exmem, div0_exmem, err_exmem
    );

endinterface

// File: rtl/exec_muldiv_stage_muldiv_iter.sv
// Iterative multiply / unsigned divide engine. One shift-add (MUL) or one
// restoring-division (DIVU/REMU) step per cycle while step_i is high; the
// controlling FSM lives in the stage top level.
module muldiv_iter
    import exec_md_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             step_i,
    input  md_kind_e         kind_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             cnt_zero_o,
    output logic             div0_o,
    output logic [WIDTH-1:0] res_o
);

    localparam int CNT_W = $clog2(WIDTH);

    // acc: product accumulator (MUL) or partial remainder (DIV)
    // opa: shifting multiplicand (MUL) or dividend/quotient shift register (DIV)
    // opb: shifting multiplier (MUL) or fixed divisor (DIV)
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_kind_e         kind_q, kind_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             div0_q, div0_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    // Next-state: load on start, otherwise advance one step when enabled
    always_comb begin
        cnt_d  = cnt_q;
        kind_d = kind_q;
        acc_d  = acc_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        div0_d = div0_q;
        // Remainder shifted left with the next dividend bit brought in; a
        // clear top bit of the difference means the divisor fits.
        trial  = {acc_q, opa_q[WIDTH-1]};
        diff   = trial - {1'b0, opb_q};
        if (start_i) begin
            cnt_d  = CNT_W'(WIDTH - 1);
            kind_d = kind_i;
            acc_d  = '0;
            opa_d  = a_i;
            opb_d  = b_i;
            div0_d = (kind_i != MD_MUL) && (b_i == '0);
        end else if (step_i) begin
            if (cnt_q != '0)
                cnt_d = cnt_q - CNT_W'(1);
            if (kind_q == MD_MUL) begin
                if (opb_q[0])
                    acc_d = acc_q + opa_q;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
            end else begin
                // A zero divisor always fits, which naturally yields an
                // all-ones quotient and leaves the dividend as remainder.
                if (!diff[WIDTH]) begin
                    acc_d = diff[WIDTH-1:0];
                    opa_d = {opa_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = trial[WIDTH-1:0];
                    opa_d = {opa_q[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // Engine registers; reset clears the counter and discards partial results
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            kind_q <= MD_MUL;
            acc_q  <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            div0_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            kind_q <= kind_d;
            acc_q  <= acc_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            div0_q <= div0_d;
        end
    end

    assign cnt_zero_o = (cnt_q == '0);
    assign div0_o     = div0_q;
    assign res_o      = (kind_q == MD_DIVU) ? opa_q : acc_q;

endmodule

// File: rtl/exec_muldiv_stage.sv
// Execute stage: single-cycle ALU for ADD..SLT, an FSM sequencing the
// iterative MUL/DIVU/REMU engine, and the EX/MEM pipeline register.
module exec_muldiv_stage
    import exec_md_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RADDR = 3
) (
    input logic                clk,
    input logic                rst,
    exec_muldiv_stage_if.slave ex_io
);

    state_e           state_q;
    logic             is_md;
    logic             is_ill;
    logic             accept;
    logic             busy;
    logic             iter_zero;
    logic             iter_div0;
    logic [WIDTH-1:0] iter_res;
    logic [WIDTH-1:0] alu_res;

    logic [WIDTH-1:0] res_q, res_d;
    logic [RADDR-1:0] wr_q, wr_d;
    logic             rw_q, rw_d;
    logic             vld_q, vld_d;
    logic             div0_q, div0_d;
    logic             err_q, err_d;

    function automatic logic [WIDTH-1:0] alu_f(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign is_md   = is_md_op(ex_io.op);
    assign is_ill  = is_illegal_op(ex_io.op);
    assign alu_res = alu_f(ex_io.op, ex_io.op_a, ex_io.op_b);

    // A mul/div is taken only when the slot downstream is free, but it
    // already stalls upstream in its presentation cycle.
    assign accept = (state_q == ST_IDLE) && ex_io.in_valid && is_md &&
                    !ex_io.flush && !ex_io.mem_stall;
    assign busy   = ((state_q == ST_IDLE) && ex_io.in_valid && is_md && !ex_io.flush) ||
                    (state_q == ST_MUL) || (state_q == ST_DIV);

    assign ex_io.stall_out = busy || ex_io.mem_stall;

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk        (clk),
        .rst        (rst),
        .start_i    (accept),
        .step_i     ((state_q == ST_MUL) || (state_q == ST_DIV)),
        .kind_i     (md_kind_of(ex_io.op)),
        .a_i        (ex_io.op_a),
        .b_i        (ex_io.op_b),
        .cnt_zero_o (iter_zero),
        .div0_o     (iter_div0),
        .res_o      (iter_res)
    );

    // Control FSM: flush aborts any in-flight operation even under mem_stall
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept)
                        state_q <= (ex_io.op == OP_MUL) ? ST_MUL : ST_DIV;
                end
                ST_MUL, ST_DIV: begin
                    if (ex_io.flush)
                        state_q <= ST_IDLE;
                    else if (iter_zero)
                        state_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (ex_io.flush || !ex_io.mem_stall)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // EX/MEM next value: hold under mem_stall, otherwise result or bubble
    always_comb begin
        res_d  = res_q;
        wr_d   = wr_q;
        rw_d   = rw_q;
        vld_d  = vld_q;
        div0_d = div0_q;
        err_d  = err_q;
        if (!ex_io.mem_stall) begin
            res_d  = '0;
            wr_d   = '0;
            rw_d   = 1'b0;
            vld_d  = 1'b0;
            div0_d = 1'b0;
            err_d  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ex_io.in_valid && !ex_io.flush) begin
                        if (is_ill) begin
                            wr_d  = ex_io.wr_reg;
                            vld_d = 1'b1;
                            err_d = 1'b1;
                        end else if (!is_md) begin
                            res_d = alu_res;
                            wr_d  = ex_io.wr_reg;
                            rw_d  = ex_io.reg_write;
                            vld_d = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!ex_io.flush) begin
                        res_d  = iter_res;
                        wr_d   = ex_io.wr_reg;
                        rw_d   = ex_io.reg_write;
                        vld_d  = 1'b1;
                        div0_d = iter_div0;
                    end
                end
                default: ;
            endcase
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q  <= '0;
            wr_q   <= '0;
            rw_q   <= 1'b0;
            vld_q  <= 1'b0;
            div0_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            res_q  <= res_d;
            wr_q   <= wr_d;
            rw_q   <= rw_d;
            vld_q  <= vld_d;
            div0_q <= div0_d;
            err_q  <= err_d;
        end
    end

    assign ex_io.res_exmem       = res_q;
    assign ex_io.wr_reg_exmem    = wr_q;
    assign ex_io.reg_write_exmem = rw_q;
    assign ex_io.valid_exmem     = vld_q;
    assign ex_io.div0_exmem      = div0_q;
    assign ex_io.err_exmem       = err_q;

endmodule

// File: doc/exec_muldiv_stage.md
EXEC_MULDIV_STAGE -- requirements
Module: exec_muldiv_stage

Interface
REQ-001 Parameter WIDTH, default 16: datapath width in bits; legal range 8..32.
REQ-002 Parameter RADDR, default 3: destination register index width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  ID/EX holds a live instruction.
REQ-006 op  input  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 MUL (low WIDTH bits), 7 DIVU, 8 REMU; 9..15 illegal.
REQ-007 op_a, op_b  input  WIDTH each  source operands.
REQ-008 wr_reg  input  RADDR  destination register; reg_write  input  1  instruction writes the register file.
REQ-009 flush  input  1  kill the instruction currently in EX.
REQ-010 mem_stall  input  1  downstream cannot accept; hold EX/MEM.
REQ-011 stall_out  output  1  upstream must hold ID/EX.
REQ-012 res_exmem  output  WIDTH; wr_reg_exmem  output  RADDR; reg_write_exmem, valid_exmem, div0_exmem, err_exmem  output  1 each; all registered EX/MEM contents.

Function
REQ-013 Ops 0..5 are single-cycle: result written into EX/MEM at the edge ending the presentation cycle; stall_out stays 0.
REQ-014 ADD/SUB wrap modulo 2^WIDTH; SLT yields 1 or 0, zero-extended to WIDTH.
REQ-015 FSM states: IDLE, MUL, DIV, DONE.
REQ-016 IDLE with in_valid=1, op 6/7/8, flush=0, mem_stall=0: latch operands, load iteration counter with WIDTH-1, go to MUL (op 6) or DIV (op 7/8).
REQ-017 MUL performs one shift-add step per cycle; DIV performs one restoring-division step per cycle.
REQ-018 In MUL/DIV, counter==0 moves to DONE; otherwise counter decrements.
REQ-019 stall_out = 1 in the accept cycle and in every MUL/DIV cycle (WIDTH+1 cycles total); 0 in DONE unless mem_stall=1.
REQ-020 DONE with mem_stall=0: EX/MEM loads the mul/div result with the ID/EX control fields, and the FSM returns to IDLE.
REQ-021 End-to-end latency: a mul/div result appears on res_exmem WIDTH+2 cycles after first presentation.
REQ-022 While stall_out=1, EX/MEM loads a bubble: valid_exmem=0, reg_write_exmem=0.
REQ-023 DIVU/REMU with op_b=0: full latency; quotient all-ones, remainder = op_a, div0_exmem=1.
REQ-024 Illegal op: EX/MEM loads valid=1, reg_write=0, err_exmem=1, res=0; single cycle.
REQ-025 mem_stall=1: EX/MEM holds its value, the FSM holds in DONE, and IDLE accepts nothing; stall_out = busy OR mem_stall.
REQ-026 flush=1 in IDLE: the instruction becomes a bubble.
REQ-027 flush=1 in MUL/DIV/DONE: the FSM returns to IDLE next edge, no result is written, and stall_out falls next cycle.
REQ-028 flush together with mem_stall: EX/MEM is held and the FSM is still aborted.
REQ-029 A back-to-back mul/div after DONE is accepted in the following IDLE cycle.

Reset
REQ-030 rst=1 at an edge: FSM goes to IDLE, counter 0, all EX/MEM outputs 0, stall_out 0 the next cycle.
REQ-031 Reset mid-operation discards the partial result; reset has priority over flush and mem_stall.

Structure
REQ-032 Op codes, FSM state encoding and default WIDTH live in shared package exec_md_pkg.
REQ-033 The iterative engine (operand/accumulator registers, counter, step logic) is sub-module muldiv_iter.
REQ-034 The top level holds the single-cycle ALU, the FSM and the EX/MEM register.

Verification (WIDTH=16)
REQ-035 MUL 0x0003*0x0005: stall_out high 17 cycles; res_exmem=0x000F, reg_write_exmem=1 at cycle 18.
REQ-036 DIVU 100/7 gives 0x000E; REMU 100/7 gives 0x0002; DIVU 0x1234/0 gives 0xFFFF with div0_exmem=1.
REQ-037 ADD 0xFFFF+0x0001 gives res 0x0000 next cycle with stall_out=0; SLT 0x8000,0x0001 gives 0x0001.
REQ-038 flush in cycle 5 of a MUL: stall_out 0 from cycle 6, no reg_write_exmem pulse; the next ADD completes normally.
REQ-039 mem_stall high 3 cycles at DONE: res_exmem is held and the result is loaded once mem_stall drops.
REQ-040 rst pulse mid-DIV and op=12: the FSM returns to IDLE with outputs 0; op=12 gives err_exmem=1 with reg_write_exmem=0.
